// File: rtl/phase_arbiter.sv
// Round-robin, demand-driven phase scheduler with yellow/all-red clearance and direct lamp decode.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module phase_arbiter #(
   parameter int unsigned GREEN_MIN = 5,
   parameter int unsigned GREEN_MAX = 20,
   parameter int unsigned GREEN_EXT = 5,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned PED_T     = 10,
   parameter int unsigned CW        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic [2:0] main_num,
   input  logic [2:0] left_num,
   input  logic [2:0] sec_num,
   input  logic [2:0] p_num,
   input  logic       m_emergency,
   input  logic       s_emergency,
   output logic [3:0] m_LRYG,
   output logic [2:0] s_RYG,
   output logic       ped,
   output logic [1:0] cur_phase,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StGreen  = 2'd0,
      StYellow = 2'd1,
      StAllRed = 2'd2
   } state_e;

   localparam logic [1:0] PhMg = 2'd0;
   localparam logic [1:0] PhMl = 2'd1;
   localparam logic [1:0] PhSg = 2'd2;
   localparam logic [1:0] PhPg = 2'd3;

   localparam logic [CW-1:0] GreenMinC = CW'(GREEN_MIN);
   localparam logic [CW-1:0] GmaxBaseC = CW'(GREEN_MAX);
   localparam logic [CW-1:0] GmaxExtC  = CW'(GREEN_MAX + GREEN_EXT);
   localparam logic [CW-1:0] YellowC   = CW'(YELLOW_T);
   localparam logic [CW-1:0] AllRedC   = CW'(ALLRED_T);
   localparam logic [CW-1:0] PedC      = CW'(PED_T);

   state_e        state_q, state_d;
   logic [1:0]    cur_q, cur_d;
   logic [1:0]    nxt_q, nxt_d;
   logic [CW-1:0] timer_q, timer_d;

   logic [CW-1:0] k;
   logic [CW-1:0] gmax;
   logic [3:0]    demand;
   logic [2:0]    own_cnt;
   logic          own_dem;
   logic          other_dem;
   logic          green_exit;

   // First demanding phase after cur in rotation; lowest offset wins, M_G when none.
   function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] dem);
      logic [1:0] cand;
      pick_next = PhMg;
      for (int i = 3; i >= 1; i--) begin
         cand = cur + 2'(i);
         if (dem[cand]) pick_next = cand;
      end
   endfunction

   assign demand    = {p_num != 3'd0, sec_num != 3'd0, left_num != 3'd0, main_num != 3'd0};
   assign own_dem   = demand[cur_q];
   assign other_dem = |(demand & ~(4'b0001 << cur_q));
   assign k         = (timer_q == {CW{1'b1}}) ? timer_q : timer_q + CW'(1);

   always_comb begin
      own_cnt = main_num;
      case (cur_q)
         PhMl:    own_cnt = left_num;
         PhSg:    own_cnt = sec_num;
         PhPg:    own_cnt = p_num;
         default: own_cnt = main_num;
      endcase
   end

   assign gmax = (own_cnt >= 3'd4) ? GmaxExtC : GmaxBaseC;

`ifdef EMERGENCY_PREEMPT_EN
   logic       em_act;
   logic [1:0] em_tgt;
   assign em_act = m_emergency | s_emergency;
   assign em_tgt = m_emergency ? PhMg : PhSg;
`else
   logic unused_emergency;
   assign unused_emergency = m_emergency ^ s_emergency;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAllRed;
         cur_q   <= PhMg;
         nxt_q   <= PhMg;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         nxt_q   <= nxt_d;
         timer_q <= timer_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      timer_d    = sec_tick ? k : timer_q;
      green_exit = 1'b0;
      unique case (state_q)
         StGreen: begin
            if (sec_tick) begin
               if (cur_q == PhPg) begin
                  green_exit = (k >= PedC);
               end else if (other_dem) begin
                  green_exit = ((k >= GreenMinC) && !own_dem) || (k >= gmax);
               end else begin
                  // Only M_G may rest without demand; other greens fall back to M_G.
                  green_exit = (cur_q != PhMg) && (k >= GreenMinC);
               end
            end
            if (green_exit) begin
               state_d = StYellow;
               nxt_d   = pick_next(cur_q, demand);
               timer_d = '0;
            end
         end
         StYellow: begin
            if (sec_tick && (k >= YellowC)) begin
               state_d = StAllRed;
               timer_d = '0;
            end
         end
         StAllRed: begin
            if (sec_tick && (k >= AllRedC)) begin
               state_d = StGreen;
               cur_d   = nxt_q;
               timer_d = '0;
            end
         end
         default: begin
            state_d = StAllRed;
            timer_d = '0;
         end
      endcase
`ifdef EMERGENCY_PREEMPT_EN
      if (em_act) begin
         if (state_q == StGreen) begin
            if (cur_q != em_tgt) begin
               state_d = StYellow;
               nxt_d   = em_tgt;
               timer_d = '0;
            end else begin
               state_d = StGreen;
               nxt_d   = nxt_q;
               timer_d = sec_tick ? k : timer_q;
            end
         end else begin
            nxt_d = em_tgt;
            if ((state_q == StAllRed) && (state_d == StGreen)) cur_d = em_tgt;
         end
      end
`endif
   end

   // Lamp decode from registered state only
   always_comb begin
      m_LRYG = 4'b0100;
      s_RYG  = 3'b100;
      ped    = 1'b0;
      unique case (state_q)
         StGreen: begin
            case (cur_q)
               PhMg:    m_LRYG = 4'b0001;
               PhMl:    m_LRYG = 4'b1100;
               PhSg:    s_RYG  = 3'b001;
               default: ped    = 1'b1;
            endcase
         end
         StYellow: begin
            if ((cur_q == PhMg) || (cur_q == PhMl)) m_LRYG = 4'b0010;
            else if (cur_q == PhSg) s_RYG = 3'b010;
         end
         default: ;
      endcase
   end

   assign cur_phase = cur_q;
   assign state     = state_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Directed-vector bench for phase_arbiter; expectations are hand-computed from default timing.
module tb_phase_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sec_tick = 1'b0;
   logic [2:0] main_num = 3'd0;
   logic [2:0] left_num = 3'd0;
   logic [2:0] sec_num = 3'd0;
   logic [2:0] p_num = 3'd0;
   logic       m_emergency = 1'b0;
   logic       s_emergency = 1'b0;
   logic [3:0] m_LRYG;
   logic [2:0] s_RYG;
   logic       ped;
   logic [1:0] cur_phase;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   phase_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .sec_tick    (sec_tick),
      .main_num    (main_num),
      .left_num    (left_num),
      .sec_num     (sec_num),
      .p_num       (p_num),
      .m_emergency (m_emergency),
      .s_emergency (s_emergency),
      .m_LRYG      (m_LRYG),
      .s_RYG       (s_RYG),
      .ped         (ped),
      .cur_phase   (cur_phase),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Packed view: {state, cur_phase, m_LRYG, s_RYG, ped}
   function automatic logic [11:0] ex(input logic [1:0] st, input logic [1:0] ph,
                                      input logic [3:0] m, input logic [2:0] s, input logic p);
      ex = {st, ph, m, s, p};
   endfunction

   logic [11:0] mg_g, ml_g, sg_g, pg_g, y_mg, y_ml, y_sg, y_pg, ar0, ar1, ar2, ar3;

   task automatic chk(input string tag, input logic [11:0] expv);
      logic [11:0] obs;
      obs = {state, cur_phase, m_LRYG, s_RYG, ped};
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%03h expected=%03h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sec_tick = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One sec_tick edge followed by one idle edge.
   task automatic tick();
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      mg_g = ex(2'd0, 2'd0, 4'b0001, 3'b100, 1'b0);
      ml_g = ex(2'd0, 2'd1, 4'b1100, 3'b100, 1'b0);
      sg_g = ex(2'd0, 2'd2, 4'b0100, 3'b001, 1'b0);
      pg_g = ex(2'd0, 2'd3, 4'b0100, 3'b100, 1'b1);
      y_mg = ex(2'd1, 2'd0, 4'b0010, 3'b100, 1'b0);
      y_ml = ex(2'd1, 2'd1, 4'b0010, 3'b100, 1'b0);
      y_sg = ex(2'd1, 2'd2, 4'b0100, 3'b010, 1'b0);
      y_pg = ex(2'd1, 2'd3, 4'b0100, 3'b100, 1'b0);
      ar0  = ex(2'd2, 2'd0, 4'b0100, 3'b100, 1'b0);
      ar1  = ex(2'd2, 2'd1, 4'b0100, 3'b100, 1'b0);
      ar2  = ex(2'd2, 2'd2, 4'b0100, 3'b100, 1'b0);
      ar3  = ex(2'd2, 2'd3, 4'b0100, 3'b100, 1'b0);

      // No demand: all-red for one tick, then M_G rests.
      do_reset();
      chk("reset", ar0);
      repeat (3) @(negedge clk);
      chk("reset_idle", ar0);
      tick();
      chk("first_mg", mg_g);
      ticks(9);
      chk("mg_rest", mg_g);

      // Secondary demand only: M_G ends at GREEN_MIN.
      do_reset();
      tick();
      sec_num = 3'd2;
      ticks(4);
      chk("mg_before_min", mg_g);
      repeat (3) @(negedge clk);
      chk("no_change_between_ticks", mg_g);
      tick();
      chk("mg_yellow_at5", y_mg);
      ticks(2);
      chk("yellow_hold", y_mg);
      tick();
      chk("allred_at8", ar0);
      tick();
      chk("sg_at9", sg_g);
      ticks(4);
      chk("sg_before_min", sg_g);
      tick();
      chk("sg_yellow_alone", y_sg);
      ticks(3);
      chk("sg_allred", ar2);
      tick();
      chk("sg_returns_mg", mg_g);

      // Own count >= 4 extends the contested green to 25.
      main_num = 3'd5;
      sec_num  = 3'd1;
      do_reset();
      tick();
      ticks(24);
      chk("ext_hold_24", mg_g);
      tick();
      chk("ext_end_25", y_mg);

      // Own count 3: contested green ends at GREEN_MAX.
      main_num = 3'd3;
      do_reset();
      tick();
      ticks(19);
      chk("max_hold_19", mg_g);
      tick();
      chk("max_end_20", y_mg);

      // Full rotation M_G -> M_L -> S_G -> P_G -> M_L.
      main_num = 3'd0;
      left_num = 3'd1;
      sec_num  = 3'd1;
      p_num    = 3'd1;
      do_reset();
      tick();
      ticks(5);
      chk("rot_mg_yellow", y_mg);
      ticks(3);
      chk("rot_allred0", ar0);
      tick();
      chk("rot_ml", ml_g);
      ticks(19);
      chk("rot_ml_hold", ml_g);
      tick();
      chk("rot_ml_yellow", y_ml);
      ticks(3);
      chk("rot_allred1", ar1);
      tick();
      chk("rot_sg", sg_g);
      ticks(20);
      chk("rot_sg_yellow", y_sg);
      ticks(3);
      chk("rot_allred2", ar2);
      tick();
      chk("rot_pg", pg_g);
      ticks(9);
      chk("rot_pg_walk9", pg_g);
      tick();
      chk("rot_pg_end10", y_pg);
      ticks(3);
      chk("rot_allred3", ar3);
      tick();
      chk("rot_wrap_ml", ml_g);

      // Reset mid-S_G with a coincident tick.
      left_num = 3'd0;
      p_num    = 3'd0;
      sec_num  = 3'd2;
      do_reset();
      tick();
      ticks(5);
      ticks(4);
      chk("pre_rst_sg", sg_g);
      ticks(2);
      @(negedge clk);
      rst = 1'b1;
      sec_tick = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sec_tick = 1'b0;
      chk("rst_mid_sg", ar0);
      repeat (2) @(negedge clk);
      chk("rst_tick_discarded", ar0);
      tick();
      chk("rst_recover_mg", mg_g);

      sec_num = 3'd0;
`ifdef EMERGENCY_PREEMPT_EN
      do_reset();
      tick();
      ticks(2);
      s_emergency = 1'b1;
      @(negedge clk);
      s_emergency = 1'b0;
      chk("em_s_yellow", y_mg);
      ticks(3);
      chk("em_s_allred", ar0);
      tick();
      chk("em_s_sg", sg_g);

      do_reset();
      tick();
      ticks(2);
      s_emergency = 1'b1;
      @(negedge clk);
      s_emergency = 1'b0;
      m_emergency = 1'b1;
      chk("em_m_yellow", y_mg);
      ticks(3);
      chk("em_m_allred", ar0);
      tick();
      chk("em_m_wins", mg_g);
      ticks(30);
      chk("em_m_hold", mg_g);
      m_emergency = 1'b0;
`else
      do_reset();
      tick();
      ticks(2);
      s_emergency = 1'b1;
      repeat (3) @(negedge clk);
      chk("em_ignored_s", mg_g);
      m_emergency = 1'b1;
      ticks(6);
      s_emergency = 1'b0;
      m_emergency = 1'b0;
      chk("em_ignored_both", mg_g);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
